// File: rtl/riscv_pkg.sv
// Shared RV32 definitions used by the M-extension sequencer and by decode.
package riscv_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  function automatic logic src_a_signed(input muldiv_op_e op);
    return op inside {MULH, MULHSU, DIV, REM};
  endfunction

  function automatic logic src_b_signed(input muldiv_op_e op);
    return op inside {MULH, DIV, REM};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on a {hi,lo} register pair.
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] opd_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    sum    = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opd_i} : '0);
    rem_sh = {hi_i, lo_i[WIDTH-1]};
    ge     = (rem_sh >= {1'b0, opd_i});
    // Remainder after a successful subtract is below the divisor, so modulo-2^WIDTH is exact
    diff   = rem_sh[WIDTH-1:0] - opd_i;
    if (is_div_i) begin
      hi_o = ge ? diff : rem_sh[WIDTH-1:0];
      lo_o = {lo_i[WIDTH-2:0], ge};
    end else begin
      hi_o = sum[WIDTH:1];
      lo_o = {sum[0], lo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M unit: one mul/div step per cycle, stalls EX until the result is ready.
module muldiv_sequencer
  import riscv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             flush,
  output logic             ready,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] Result
);

  localparam logic [WIDTH-1:0]   ONE     = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE2    = (2*WIDTH)'(1);
  localparam logic [WIDTH-1:0]   MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0]   LAST    = CNT_W'(WIDTH-1);

  muldiv_state_e    state_q, state_d;
  muldiv_op_e       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opd_q, opd_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0]   step_hi, step_lo;
  muldiv_op_e         op_in;
  logic               sa, sb, div_zero, div_ovf;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, final_res;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (op_q[2]),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .opd_i    (opd_q),
    .hi_o     (step_hi),
    .lo_o     (step_lo)
  );

  always_comb begin
    op_in    = muldiv_op_e'(Funct3);
    sa       = src_a_signed(op_in) & SrcA[WIDTH-1];
    sb       = src_b_signed(op_in) & SrcB[WIDTH-1];
    mag_a    = sa ? (~SrcA + ONE) : SrcA;
    mag_b    = sb ? (~SrcB + ONE) : SrcB;
    div_zero = Funct3[2] && (SrcB == '0);
    div_ovf  = (op_in == DIV || op_in == REM) && (SrcA == MIN_NEG) && (SrcB == '1);

    // Fix-up works on the last step's outputs so Result is registered on entry to DONE
    prod     = {step_hi, step_lo};
    prod_fix = neg_q ? (~prod + ONE2) : prod;
    quo_fix  = neg_q ? (~step_lo + ONE) : step_lo;
    rem_fix  = neg_q ? (~step_hi + ONE) : step_hi;
    case (op_q)
      MUL:                 final_res = prod_fix[WIDTH-1:0];
      MULH, MULHSU, MULHU: final_res = prod_fix[2*WIDTH-1:WIDTH];
      DIV, DIVU:           final_res = quo_fix;
      default:             final_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opd_d    = opd_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (!flush && start) begin
          if (div_zero) begin
            result_d = Funct3[1] ? SrcA : '1;
            state_d  = DONE;
          end else if (div_ovf) begin
            result_d = Funct3[1] ? '0 : MIN_NEG;
            state_d  = DONE;
          end else begin
            op_d    = op_in;
            neg_d   = (op_in == REM) ? sa : (sa ^ sb);
            hi_d    = '0;
            lo_d    = Funct3[2] ? mag_a : mag_b;
            opd_d   = Funct3[2] ? mag_b : mag_a;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            result_d = final_res;
            state_d  = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= MUL;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opd_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opd_q    <= opd_d;
      result_q <= result_d;
    end
  end

  assign ready  = (state_q == IDLE);
  assign done   = (state_q == DONE);
  assign stall  = start & ~done;
  assign Result = result_q;

endmodule
